// File: rtl/bit_stream_sub_fsm_if.sv
// Bit-serial subtractor stream bundle.
// master drives in_valid/sof/S/A(/mode); slave returns D/out_valid/eow/borrow_out.
// Optional mode signal exists when BIT_STREAM_SUB_ADD_MODE_EN is defined.
interface bit_stream_sub_fsm_if;
   logic in_valid;
   logic sof;
   logic S;
   logic A;
   logic D;
   logic out_valid;
   logic eow;
   logic borrow_out;
`ifdef BIT_STREAM_SUB_ADD_MODE_EN
   logic mode;

   modport master (
      output in_valid, sof, S, A, mode,
      input  D, out_valid, eow, borrow_out
   );

   modport slave (
      input  in_valid, sof, S, A, mode,
      output D, out_valid, eow, borrow_out
   );
`else
   modport master (
      output in_valid, sof, S, A,
      input  D, out_valid, eow, borrow_out
   );

   modport slave (
      input  in_valid, sof, S, A,
      output D, out_valid, eow, borrow_out
   );
`endif
endinterface

// File: rtl/bit_stream_sub_fsm.sv
// Bit-serial LSB-first subtractor D = S - A with word framing and end-of-word borrow.
// Ports: clk, rst (async active-high), bus (slave): in_valid, sof, S, A -> D, out_valid, eow, borrow_out.
// Define BIT_STREAM_SUB_ADD_MODE_EN to add a per-word mode input (1 = add, carry on borrow_out).
module bit_stream_sub_fsm #(
   parameter  int WORD_LEN = 16,
   localparam int CNT_W    = $clog2(WORD_LEN)
) (
   input logic                 clk,
   input logic                 rst,
   bit_stream_sub_fsm_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN_NB = 2'd1,
      RUN_B  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_LEN - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             d_q, d_d;
   logic             out_valid_q, out_valid_d;
   logic             eow_q, eow_d;
   logic             borrow_q, borrow_d;

   logic in_run;
   logic start;
   logic run_bit;
   logic accept;
   logic last;
   logic br;
   logic mode_cur;
   logic d_bit;
   logic nxt_sub;
   logic nxt_add;
   logic br_nxt;

`ifdef BIT_STREAM_SUB_ADD_MODE_EN
   logic mode_q, mode_d;
`endif

   // sof always restarts a word, even mid-word, with borrow forced to 0
   assign in_run  = (state_q != IDLE);
   assign start   = bus.in_valid & bus.sof;
   assign run_bit = bus.in_valid & ~bus.sof & in_run;
   assign accept  = start | run_bit;
   assign last    = run_bit & (cnt_q == LAST);
   assign br      = run_bit & (state_q == RUN_B);

`ifdef BIT_STREAM_SUB_ADD_MODE_EN
   // mode is taken live on the sof bit, then held for the word
   assign mode_cur = start ? bus.mode : mode_q;
`else
   assign mode_cur = 1'b0;
`endif

   assign d_bit   = bus.S ^ bus.A ^ br;
   assign nxt_sub = (~bus.S & bus.A) | (~(bus.S ^ bus.A) & br);
   assign nxt_add = (bus.S & bus.A) | (br & (bus.S ^ bus.A));
   assign br_nxt  = mode_cur ? nxt_add : nxt_sub;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         d_q         <= 1'b0;
         out_valid_q <= 1'b0;
         eow_q       <= 1'b0;
         borrow_q    <= 1'b0;
`ifdef BIT_STREAM_SUB_ADD_MODE_EN
         mode_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         d_q         <= d_d;
         out_valid_q <= out_valid_d;
         eow_q       <= eow_d;
         borrow_q    <= borrow_d;
`ifdef BIT_STREAM_SUB_ADD_MODE_EN
         mode_q      <= mode_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
`ifdef BIT_STREAM_SUB_ADD_MODE_EN
      mode_d  = mode_q;
`endif
      unique case (1'b1)
         start: begin
            state_d = br_nxt ? RUN_B : RUN_NB;
            cnt_d   = CNT_W'(1);
`ifdef BIT_STREAM_SUB_ADD_MODE_EN
            mode_d  = bus.mode;
`endif
         end
         run_bit: begin
            if (last) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               state_d = br_nxt ? RUN_B : RUN_NB;
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   // D holds through stalls; flags are single-cycle pulses
   always_comb begin
      out_valid_d = accept;
      d_d         = accept ? d_bit : d_q;
      eow_d       = last;
      borrow_d    = last & br_nxt;
   end

   assign bus.D          = d_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.eow        = eow_q;
   assign bus.borrow_out = borrow_q;

endmodule
